// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end.
// Fetches 32-bit instruction words from a memory-mapped instruction store
// and splits each word into Opcode/Dest/Src1/Src2. Each decoded instruction
// is offered to the execution engine with a valid/ready handshake.
// A fetch takes two cycles, REQ then WAIT.
// Opcode FFh is a stop: the unit halts and does not offer that word.
// Fetching runs from PC 0 up to PC_LAST. Accepting the instruction at
// PC_LAST halts the unit with the sticky Overrun flag set.
// Optional feature macro: IFETCH_OPCODE_CHECK_EN. When it is defined, any
// opcode outside the legal set halts the unit with IllegalOp set. When it is
// undefined, every non-stop opcode is offered unchanged and IllegalOp stays 0.

module instr_fetch_decode #(
   parameter logic [3:0]  INSTR_SEL = 4'h1,
   parameter logic [11:0] PC_LAST   = 12'h009
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   output logic [15:0]  address,
   output logic         nRead,
   input  logic [255:0] DataIn,
   output logic [7:0]   Opcode,
   output logic [7:0]   Dest,
   output logic [7:0]   Src1,
   output logic [7:0]   Src2,
   output logic         InstrValid,
   input  logic         InstrReady,
   output logic [11:0]  PC,
   output logic         Busy,
   output logic         Halted,
   output logic         Overrun,
   output logic         IllegalOp
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   localparam logic [7:0] OP_STOP = 8'hFF;

   state_t      state_r;
   logic [11:0] pc_inc_s;
   logic [31:0] instr_word_s;
   logic        unused_data_s;

   // Only the low word of the memory bus carries an instruction.
   assign instr_word_s  = DataIn[31:0];
   assign unused_data_s = ^DataIn[255:32];
   assign pc_inc_s      = PC + 12'd1;

`ifdef IFETCH_OPCODE_CHECK_EN
   // Legal opcode set: 00h-05h, 10h-13h and the FFh stop code.
   function automatic logic is_legal_op(input logic [7:0] op);
      logic legal_v;
      legal_v = 1'b0;
      if (op <= 8'h05) begin
         legal_v = 1'b1;
      end else if ((op >= 8'h10) && (op <= 8'h13)) begin
         legal_v = 1'b1;
      end else if (op == OP_STOP) begin
         legal_v = 1'b1;
      end else begin
         legal_v = 1'b0;
      end
      return legal_v;
   endfunction
`endif

   // Fetch/decode sequencer; every output is a register updated alongside the state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r    <= ST_IDLE;
         address    <= 16'h0000;
         nRead      <= 1'b1;
         PC         <= 12'h000;
         Opcode     <= 8'h00;
         Dest       <= 8'h00;
         Src1       <= 8'h00;
         Src2       <= 8'h00;
         InstrValid <= 1'b0;
         Busy       <= 1'b0;
         Halted     <= 1'b0;
         Overrun    <= 1'b0;
         IllegalOp  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (Start) begin
                  PC      <= 12'h000;
                  address <= {INSTR_SEL, 12'h000};
                  nRead   <= 1'b0;
                  Busy    <= 1'b1;
                  state_r <= ST_REQ;
               end
            end

            ST_REQ: begin
               // Strobe lasts one cycle; the address stays put while data returns.
               nRead   <= 1'b1;
               state_r <= ST_WAIT;
            end

            ST_WAIT: begin
               // Capture is unconditional so a stop/illegal word remains visible after halting.
               Opcode  <= instr_word_s[31:24];
               Dest    <= instr_word_s[23:16];
               Src1    <= instr_word_s[15:8];
               Src2    <= instr_word_s[7:0];
               address <= 16'h0000;
               if (instr_word_s[31:24] == OP_STOP) begin
                  Busy    <= 1'b0;
                  Halted  <= 1'b1;
                  state_r <= ST_HALT;
`ifdef IFETCH_OPCODE_CHECK_EN
               end else if (!is_legal_op(instr_word_s[31:24])) begin
                  IllegalOp <= 1'b1;
                  Busy      <= 1'b0;
                  Halted    <= 1'b1;
                  state_r   <= ST_HALT;
`endif
               end else begin
                  InstrValid <= 1'b1;
                  state_r    <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               // Fields and PC are held untouched until the engine accepts.
               if (InstrReady) begin
                  InstrValid <= 1'b0;
                  if (PC < PC_LAST) begin
                     PC      <= pc_inc_s;
                     address <= {INSTR_SEL, pc_inc_s};
                     nRead   <= 1'b0;
                     state_r <= ST_REQ;
                  end else begin
                     // Ran off the end of the program without a stop; PC stays at PC_LAST.
                     Overrun <= 1'b1;
                     Busy    <= 1'b0;
                     Halted  <= 1'b1;
                     state_r <= ST_HALT;
                  end
               end
            end

            ST_HALT: begin
               if (Start) begin
                  Overrun   <= 1'b0;
                  IllegalOp <= 1'b0;
                  PC        <= 12'h000;
                  address   <= {INSTR_SEL, 12'h000};
                  nRead     <= 1'b0;
                  Busy      <= 1'b1;
                  Halted    <= 1'b0;
                  state_r   <= ST_REQ;
               end
            end

            default: begin
               state_r    <= ST_IDLE;
               address    <= 16'h0000;
               nRead      <= 1'b1;
               InstrValid <= 1'b0;
               Busy       <= 1'b0;
               Halted     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode.
// A small program-level model predicts which addresses get fetched, which
// words get offered and how the run ends. A negedge compare process then
// checks the DUT against that model on every cycle.
// Hand-computed literal checks pin the model for the key scenarios.

module tb_instr_fetch_decode;

   localparam logic [3:0]  SEL  = 4'h1;
   localparam logic [11:0] LAST = 12'h009;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         Start;
   logic [15:0]  address;
   logic         nRead;
   logic [255:0] DataIn;
   logic [7:0]   Opcode, Dest, Src1, Src2;
   logic         InstrValid;
   logic         InstrReady;
   logic [11:0]  PC;
   logic         Busy, Halted, Overrun, IllegalOp;

   instr_fetch_decode dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .address    (address),
      .nRead      (nRead),
      .DataIn     (DataIn),
      .Opcode     (Opcode),
      .Dest       (Dest),
      .Src1       (Src1),
      .Src2       (Src2),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .PC         (PC),
      .Busy       (Busy),
      .Halted     (Halted),
      .Overrun    (Overrun),
      .IllegalOp  (IllegalOp)
   );

   always #5 Clk = ~Clk;

   // Instruction memory; the upper bus bits carry junk that must be ignored.
   logic [31:0] mem [0:15];
   assign DataIn = {{7{32'hA5A55A5A}}, mem[address[3:0]]};

   int vectors = 0;
   int errors  = 0;

   // Model state
   logic [11:0] fetch_q[$];
   logic [11:0] offer_pc_q[$];
   logic [31:0] offer_word_q[$];
   logic [11:0] exp_halt_pc;
   logic        exp_ovr, exp_ill;
   logic [31:0] exp_last;

   bit          chk_en = 1'b0;
   int          offers_seen;
   int          fetch_idx;
   logic [31:0] first_word;
   logic [11:0] first_pc;
   logic [15:0] second_fetch_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit legal_op(input logic [7:0] op);
      return (op inside {[8'h00:8'h05], [8'h10:8'h13], 8'hFF});
   endfunction

   // Walk the program as the specification describes it, from PC 0.
   task automatic build_model();
      logic [11:0] pc;
      logic [31:0] w;
      fetch_q.delete();
      offer_pc_q.delete();
      offer_word_q.delete();
      exp_ovr = 1'b0;
      exp_ill = 1'b0;
      pc = 12'h000;
      for (int n = 0; n < 16; n++) begin
         fetch_q.push_back(pc);
         w = mem[pc[3:0]];
         exp_last    = w;
         exp_halt_pc = pc;
         if (w[31:24] == 8'hFF) break;
`ifdef IFETCH_OPCODE_CHECK_EN
         if (!legal_op(w[31:24])) begin
            exp_ill = 1'b1;
            break;
         end
`endif
         offer_pc_q.push_back(pc);
         offer_word_q.push_back(w);
         if (pc == LAST) begin
            exp_ovr = 1'b1;
            break;
         end
         pc = pc + 12'd1;
      end
   endtask

   // Per-cycle compare against the model queues.
   always @(negedge Clk) begin
      if (chk_en) begin
         if (!nRead) begin
            if (fetch_q.size() == 0) begin
               check("spurious_fetch", fetch_q.size(), 1);
            end else begin
               check("fetch_addr", address, {SEL, fetch_q[0]});
               check("fetch_pc", PC, fetch_q[0]);
               if (fetch_idx == 1) second_fetch_addr = address;
               fetch_idx++;
               void'(fetch_q.pop_front());
            end
         end
         if (InstrValid) begin
            if (offer_pc_q.size() == 0) begin
               check("spurious_offer", offer_pc_q.size(), 1);
            end else begin
               check("offer_pc", PC, offer_pc_q[0]);
               check("offer_fields", {Opcode, Dest, Src1, Src2}, offer_word_q[0]);
               check("offer_bus", {address, nRead, Busy, Halted}, {16'h0000, 1'b1, 1'b1, 1'b0});
               if (InstrReady) begin
                  if (offers_seen == 0) begin
                     first_word = {Opcode, Dest, Src1, Src2};
                     first_pc   = PC;
                  end
                  offers_seen++;
                  void'(offer_pc_q.pop_front());
                  void'(offer_word_q.pop_front());
               end
            end
         end
         if (Halted) begin
            check("halt_bus", {address, nRead, Busy, InstrValid}, {16'h0000, 1'b1, 1'b0, 1'b0});
         end
      end
   end

   // Start a program from IDLE/HALT and run it to HALT.
   // mode 0: ready always high; mode 1: ready held low for 5 ISSUE cycles.
   task automatic run_program(input int mode);
      int  hold_cnt;
      bit  done;
      build_model();
      offers_seen       = 0;
      fetch_idx         = 0;
      first_word        = 32'h0;
      first_pc          = 12'hFFF;
      second_fetch_addr = 16'h0;
      hold_cnt          = 0;
      done              = 1'b0;
      InstrReady        = (mode == 0);
      chk_en            = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      check("start_clears", {Busy, Halted, Overrun, IllegalOp}, 4'b1000);
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(posedge Clk); #1;
         if (Halted) begin
            done = 1'b1;
         end else if (mode == 1) begin
            if (InstrValid) hold_cnt++;
            else hold_cnt = 0;
            InstrReady = (hold_cnt > 5);
         end else begin
            InstrReady = 1'b1;
         end
      end
      check("run_halts", done, 1'b1);
      check("model_fetches_done", fetch_q.size(), 0);
      check("model_offers_done", offer_pc_q.size(), 0);
      check("end_pc", PC, exp_halt_pc);
      check("end_flags", {Overrun, IllegalOp}, {exp_ovr, exp_ill});
      check("end_fields", {Opcode, Dest, Src1, Src2}, exp_last);
   endtask

   initial begin
      bit found;
      bit activity;
      for (int i = 0; i < 16; i++) mem[i] = 32'hFF000000;
      Reset      = 1'b1;
      Start      = 1'b0;
      InstrReady = 1'b0;

      // Reset state
      #12;
      check("rst_addr", address, 16'h0000);
      check("rst_nread", nRead, 1'b1);
      check("rst_pc", PC, 12'h000);
      check("rst_fields", {Opcode, Dest, Src1, Src2}, 32'h0);
      check("rst_flags", {InstrValid, Busy, Halted, Overrun, IllegalOp}, 5'b0);
      @(posedge Clk); #1;
      Reset = 1'b0;

      // One instruction, then a stop word
      mem[0] = 32'h01020001;
      mem[1] = 32'hFF000000;
      run_program(0);
      check("r032_offers", offers_seen, 1);
      check("r032_word", first_word, 32'h01020001);
      check("r032_pc", first_pc, 12'h000);
      check("r032_halt", {Halted, PC}, {1'b1, 12'h001});
      check("r032_opcode", Opcode, 8'hFF);

      // Back-pressure from the engine for 5 cycles
      mem[0] = 32'h03112233;
      mem[1] = 32'h10445566;
      mem[2] = 32'hFF000000;
      run_program(1);
      check("r033_next_addr", second_fetch_addr, 16'h1001);
      check("r033_offers", offers_seen, 2);
      check("r033_pc", PC, 12'h002);

      // Run off the end of the program
      for (int i = 0; i < 10; i++) mem[i] = {8'(i % 6), 8'(i), 8'h5A, 8'(i + 1)};
      for (int i = 10; i < 16; i++) mem[i] = 32'hFF000000;
      run_program(0);
      check("r034_offers", offers_seen, 10);
      check("r034_status", {Overrun, Halted, PC}, {1'b1, 1'b1, 12'h009});

      // Undefined opcode
      mem[0] = 32'h07000000;
      mem[1] = 32'hFF000000;
      run_program(0);
`ifdef IFETCH_OPCODE_CHECK_EN
      check("r036_status", {IllegalOp, Halted, PC}, {1'b1, 1'b1, 12'h000});
      check("r036_offers", offers_seen, 0);
`else
      check("r036_status", {IllegalOp, Halted, PC}, {1'b0, 1'b1, 12'h001});
      check("r036_offers", offers_seen, 1);
      check("r036_word", first_word, 32'h07000000);
`endif

      // Reset while the second word is in WAIT
      mem[0] = 32'h01020001;
      mem[1] = 32'h02030405;
      mem[2] = 32'hFF000000;
      build_model();
      offers_seen = 0;
      fetch_idx   = 0;
      InstrReady  = 1'b1;
      chk_en      = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(posedge Clk); #1;
         if (!nRead && PC == 12'h001) begin
            found = 1'b1;
            break;
         end
      end
      check("r035_reach_req", found, 1'b1);
      @(posedge Clk); #1;
      chk_en = 1'b0;
      #1;
      Reset = 1'b1;
      #1;
      check("r035_bus", {nRead, InstrValid, address}, {1'b1, 1'b0, 16'h0000});
      check("r035_pc", PC, 12'h000);
      check("r035_flags", {Busy, Halted, Opcode}, {1'b0, 1'b0, 8'h00});
      @(posedge Clk); #1;
      Reset = 1'b0;
      activity = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(posedge Clk); #1;
         if (InstrValid || !nRead || Busy) activity = 1'b1;
      end
      check("r035_quiet", activity, 1'b0);

      // Recovery from IDLE after the abandoned run
      run_program(0);
      check("recover_offers", offers_seen, 2);
      check("recover_pc", PC, 12'h002);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 Parameter INSTR_SEL, default 4'h1, value driven on address[15:12] for every fetch.
REQ-002 Parameter PC_LAST, default 12'h009, highest legal instruction address.
REQ-003 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  begin fetching from PC 0; sampled only in IDLE or HALT.
REQ-006 address  output  16  memory-mapped bus address; {INSTR_SEL, PC} during fetch, 16'h0000 otherwise.
REQ-007 nRead  output  1  active-low read strobe to instruction memory.
REQ-008 DataIn  input  256  instruction memory data; instruction in bits [31:0], bits [255:32] ignored.
REQ-009 Opcode, Dest, Src1, Src2  output  8 each  decoded fields {[31:24],[23:16],[15:8],[7:0]}.
REQ-010 InstrValid  output  1  decoded fields valid and offered to the execution engine.
REQ-011 InstrReady  input  1  execution engine accepts the offered instruction.
REQ-012 PC  output  12  address of the instruction currently fetched or offered.
REQ-013 Busy  output  1  high in REQ, WAIT, ISSUE.
REQ-014 Halted  output  1  high in HALT.
REQ-015 Overrun  output  1  sticky; PC passed PC_LAST without a stop.
REQ-016 IllegalOp  output  1  sticky; illegal opcode captured (see Configuration).

Function
REQ-017 FSM states IDLE, REQ, WAIT, ISSUE, HALT; all outputs registered.
REQ-018 IDLE: nRead=1, address=0; Start=1 -> PC<=0, go REQ.
REQ-019 REQ (exactly 1 cycle): nRead=0, address={INSTR_SEL,PC}; -> WAIT.
REQ-020 WAIT (exactly 1 cycle): nRead=1, address held; at its closing edge, DataIn[31:0] captured into Opcode/Dest/Src1/Src2.
REQ-021 After WAIT: Opcode==8'hFF -> HALT, stop not offered; otherwise -> ISSUE.
REQ-022 ISSUE: InstrValid=1, fields and PC stable until accepted; edge with InstrReady=1 -> InstrValid<=0.
REQ-023 On acceptance with PC<PC_LAST: PC<=PC+1, go REQ; fetch-to-offer latency is 2 cycles (REQ, WAIT).
REQ-024 On acceptance with PC==PC_LAST: Overrun<=1, go HALT; PC never wraps.
REQ-025 InstrReady outside ISSUE has no effect; Start outside IDLE/HALT is ignored.
REQ-026 HALT: nRead=1, address=0, fields retain last captured value; Start=1 -> clear Overrun, IllegalOp, PC<=0, go REQ.
REQ-027 Maximum throughput: one instruction per 3 cycles with InstrReady held high.

Reset
REQ-028 Reset=1 immediately (asynchronously) forces IDLE, nRead=1, address=16'h0000, PC=0, Opcode/Dest/Src1/Src2=0, InstrValid=0, Busy=0, Halted=0, Overrun=0, IllegalOp=0.
REQ-029 Reset asserted mid-fetch or mid-ISSUE abandons the instruction; nothing is offered after release until a new Start.

Configuration
REQ-030 Macro IFETCH_OPCODE_CHECK_EN defined: legal opcodes are 00h-05h, 10h-13h, FFh; any other captured opcode sets IllegalOp=1 and goes HALT without offering it.
REQ-031 Macro IFETCH_OPCODE_CHECK_EN undefined: every non-FFh opcode is offered unchanged; IllegalOp tied 0.

Verification
REQ-032 Reset, Start pulse, memory words 0=32'h01020001, 1=32'hFF000000, InstrReady=1 -> one offer Opcode=01 Dest=02 Src1=00 Src2=01 at PC=0, then Halted=1 at PC=1, InstrValid never high for FFh.
REQ-033 InstrReady held 0 for 5 cycles in ISSUE -> InstrValid, fields, PC stable for all 5; accepted on first high edge, next REQ shows address=16'h1001.
REQ-034 PC_LAST=2, words 0..2 non-stop, ready=1 -> three offers, then Overrun=1, Halted=1, PC=2.
REQ-035 Reset asserted during WAIT -> nRead=1, InstrValid=0, PC=0 same cycle; no offer after release until Start.
REQ-036 Word 0=32'h07000000 -> with IFETCH_OPCODE_CHECK_EN: IllegalOp=1, Halted=1, no offer; without: offered with Opcode=07.
